// File: rtl/add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_seq_pkg
//  Description : Shared types and widths for the add-request sequencer:
//                FSM state encoding, operand/sum widths, operand pair struct.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_seq_pkg;

    localparam int OP_W  = 4;
    localparam int SUM_W = OP_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;

endpackage : add_seq_pkg
`default_nettype wire

// File: rtl/add_req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : add_req_fifo
//  Description : Synchronous operand-pair FIFO. Head entry is visible on
//                head_o while not empty; pushes while full and pops while
//                empty are ignored.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push_i, wdata_i - write strobe and pair to store
//                pop_i           - discard head entry
//                head_o          - current head entry
//                full_o, empty_o - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module add_req_fifo
    import add_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  op_pair_t wdata_i,
    input  logic     pop_i,
    output op_pair_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    op_pair_t         mem_q [DEPTH];

    logic push_en;
    logic pop_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_en && !pop_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : add_req_fifo
`default_nettype wire

// File: rtl/add_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : add_req_sequencer
//  Description : Upstream driver for a sample/done 4-bit adder. Buffers
//                operand pairs, issues each as a one-cycle sample pulse,
//                waits for a done rising edge (or times out) and returns the
//                captured sum with operands and status flags.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                in_valid_i/in_ready_o,
//                in_a_i/in_b_i               - operand pair input stream
//                a_o/b_o/sample_o            - request to the adder
//                s_i/done_i                  - adder sum and completion
//                res_valid_o/res_ready_i,
//                res_a_o/res_b_o/res_sum_o,
//                res_timeout_o/res_mismatch_o - result output stream
//                busy_o                      - FSM active or FIFO non-empty
//  Revision    : 1.0 - initial release
// ============================================================================
module add_req_sequencer
    import add_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  in_a_i,
    input  logic [OP_W-1:0]  in_b_i,
    output logic [OP_W-1:0]  a_o,
    output logic [OP_W-1:0]  b_o,
    output logic             sample_o,
    input  logic [SUM_W-1:0] s_i,
    input  logic             done_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [OP_W-1:0]  res_a_o,
    output logic [OP_W-1:0]  res_b_o,
    output logic [SUM_W-1:0] res_sum_o,
    output logic             res_timeout_o,
    output logic             res_mismatch_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q;
    logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]  res_a_q, res_a_d, res_b_q, res_b_d;
    logic [SUM_W-1:0] res_sum_q, res_sum_d;
    logic             res_timeout_q, res_timeout_d;
    logic             res_mismatch_q, res_mismatch_d;

    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_full;
    logic     fifo_empty;
    op_pair_t fifo_head;
    op_pair_t fifo_wdata;
    logic     done_rise;

    assign fifo_wdata = '{a: in_a_i, b: in_b_i};
    assign fifo_push  = in_valid_i;

    add_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign done_rise = done_i && !done_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        a_d            = a_q;
        b_d            = b_q;
        res_a_d        = res_a_q;
        res_b_d        = res_b_q;
        res_sum_d      = res_sum_q;
        res_timeout_d  = res_timeout_q;
        res_mismatch_d = res_mismatch_q;
        fifo_pop       = 1'b0;
        case (state_q)
            IDLE: begin
                // Operands are latched on the edge entering ISSUE so they are
                // already stable when sample rises.
                if (!fifo_empty) begin
                    state_d = ISSUE;
                    a_d     = fifo_head.a;
                    b_d     = fifo_head.b;
                end
            end
            ISSUE: begin
                fifo_pop = 1'b1;
                cnt_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    res_a_d        = a_q;
                    res_b_d        = b_q;
                    res_sum_d      = s_i;
                    res_timeout_d  = 1'b0;
                    res_mismatch_d = (s_i != ({1'b0, a_q} + {1'b0, b_q}));
                    state_d        = RESULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT - 1)) begin
                        res_a_d        = a_q;
                        res_b_d        = b_q;
                        res_sum_d      = '0;
                        res_timeout_d  = 1'b1;
                        res_mismatch_d = 1'b0;
                        state_d        = RESULT;
                    end
                end
            end
            RESULT: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            done_q         <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            res_a_q        <= '0;
            res_b_q        <= '0;
            res_sum_q      <= '0;
            res_timeout_q  <= 1'b0;
            res_mismatch_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            done_q         <= done_i;
            a_q            <= a_d;
            b_q            <= b_d;
            res_a_q        <= res_a_d;
            res_b_q        <= res_b_d;
            res_sum_q      <= res_sum_d;
            res_timeout_q  <= res_timeout_d;
            res_mismatch_q <= res_mismatch_d;
        end
    end

    assign in_ready_o     = !fifo_full;
    assign a_o            = a_q;
    assign b_o            = b_q;
    assign sample_o       = (state_q == ISSUE);
    assign res_valid_o    = (state_q == RESULT);
    assign res_a_o        = res_a_q;
    assign res_b_o        = res_b_q;
    assign res_sum_o      = res_sum_q;
    assign res_timeout_o  = res_timeout_q;
    assign res_mismatch_o = res_mismatch_q;
    assign busy_o         = (state_q != IDLE) || !fifo_empty;

endmodule : add_req_sequencer
`default_nettype wire

// File: tb/tb_add_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_req_sequencer
//  Description : Scoreboard bench for add_req_sequencer. Accepted pairs queue
//                their expected result; an adder model answers each sample
//                pulse; a monitor checks results, latency and stability.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_req_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int M_NORM  = 0;  // done rises after d cycles, correct sum
    localparam int M_NEVER = 1;  // done never rises
    localparam int M_CORR  = 2;  // done rises after d cycles, sum off by one

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         mode;
        int         d;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [3:0] in_a_i = '0, in_b_i = '0;
    logic [3:0] a_o, b_o;
    logic       sample_o;
    logic [4:0] s_i = '0;
    logic       done_i = 1'b0;
    logic       res_valid_o;
    logic       res_ready_i = 1'b0;
    logic [3:0] res_a_o, res_b_o;
    logic [4:0] res_sum_o;
    logic       res_timeout_o, res_mismatch_o, busy_o;

    add_req_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i),
        .a_o(a_o), .b_o(b_o), .sample_o(sample_o),
        .s_i(s_i), .done_i(done_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_a_o(res_a_o), .res_b_o(res_b_o), .res_sum_o(res_sum_o),
        .res_timeout_o(res_timeout_o), .res_mismatch_o(res_mismatch_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    txn_t        issue_q[$];   // pairs awaiting their sample pulse
    logic [14:0] exp_q[$];     // {a,b,sum,timeout,mismatch} in order
    int          lat_q[$];     // expected cycle of res_valid rise
    int          ready_mode = 0;  // 0 always ready, 1 random, 2 stalled
    bit          spur = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Adder model: answers each sample pulse according to the pair's mode.
    initial begin
        int rise_at = -10;
        txn_t t;
        forever begin
            tick;
            if (rst) begin
                rise_at = -10;
                done_i  = 1'b0;
            end else begin
                if (sample_o) begin
                    if (issue_q.size() == 0) begin
                        fail_now("unexpected_sample");
                    end else begin
                        t = issue_q.pop_front();
                        chk("sample_ab", {a_o, b_o}, {t.a, t.b});
                        chk("sample_while_res_valid", res_valid_o, 1'b0);
                        if (t.mode == M_NEVER) begin
                            rise_at = -10;
                            s_i     = 5'($urandom);
                            lat_q.push_back(cyc + TIMEOUT);
                        end else begin
                            rise_at = cyc + t.d;
                            s_i     = 5'(int'(t.a) + int'(t.b) + ((t.mode == M_CORR) ? 1 : 0));
                            lat_q.push_back(cyc + t.d + 1);
                        end
                    end
                end
                done_i = spur || (cyc >= rise_at && cyc < rise_at + 2);
                spur   = 1'b0;
            end
        end
    end

    // Monitor: drives res_ready, checks latency, stability and result values.
    initial begin
        bit          was_valid = 1'b0;
        bit          hold = 1'b0;
        logic [15:0] held = '0;
        logic [14:0] e;
        int          l;
        forever begin
            tick;
            if (rst) begin
                res_ready_i = 1'b0;
                was_valid   = 1'b0;
                hold        = 1'b0;
            end else begin
                if (res_valid_o && !was_valid) begin
                    if (lat_q.size() == 0) begin
                        fail_now("unexpected_res_valid");
                    end else begin
                        l = lat_q.pop_front();
                        chk("res_latency_cycle", cyc, l);
                    end
                end
                if (hold) begin
                    chk("res_stable", {res_a_o, res_b_o, res_sum_o, res_timeout_o, res_mismatch_o, res_valid_o}, held);
                end
                res_ready_i = (ready_mode == 0) ? 1'b1 :
                              (ready_mode == 1) ? 1'($urandom) : 1'b0;
                hold = 1'b0;
                if (res_valid_o && res_ready_i) begin
                    if (exp_q.size() == 0) begin
                        fail_now("result_without_expectation");
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {res_a_o, res_b_o, res_sum_o, res_timeout_o, res_mismatch_o}, e);
                    end
                end else if (res_valid_o) begin
                    hold = 1'b1;
                    held = {res_a_o, res_b_o, res_sum_o, res_timeout_o, res_mismatch_o, res_valid_o};
                end
                was_valid = res_valid_o;
            end
        end
    end

    // Offer one pair; on acceptance record what the specification predicts.
    task automatic push(input logic [3:0] a, input logic [3:0] b, input int mode, input int d);
        txn_t t;
        int   n = 0;
        int   sum;
        in_a_i = a;
        in_b_i = b;
        in_valid_i = 1'b1;
        while (!in_ready_o && n < 300) begin
            tick;
            n++;
        end
        if (!in_ready_o) begin
            fail_now("push_stuck");
        end else begin
            t.a = a; t.b = b; t.mode = mode; t.d = d;
            issue_q.push_back(t);
            sum = (mode == M_NEVER) ? 0 : int'(a) + int'(b) + ((mode == M_CORR) ? 1 : 0);
            exp_q.push_back({a, b, 5'(sum), (mode == M_NEVER), (mode == M_CORR)});
        end
        tick;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_sample;
        int n = 0;
        while (!sample_o && n < 100) begin
            tick;
            n++;
        end
        if (!sample_o) fail_now("wait_sample_timeout");
    endtask

    task automatic drain;
        int n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
            tick;
            n++;
        end
        if (exp_q.size() != 0 || busy_o) fail_now("drain_timeout");
    endtask

    task automatic do_reset;
        rst = 1'b1;
        issue_q.delete();
        exp_q.delete();
        lat_q.delete();
        tick;
        tick;
        chk("reset_outputs",
            {a_o, b_o, sample_o, res_valid_o, res_a_o, res_b_o, res_sum_o, res_timeout_o, res_mismatch_o, busy_o},
            '0);
        chk("reset_in_ready", in_ready_o, 1'b1);
        rst = 1'b0;
        tick;
    endtask

    task automatic quiet_window(input string name, input int ncyc);
        bit seen = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            tick;
            if (res_valid_o || sample_o) seen = 1'b1;
        end
        chk(name, seen, 1'b0);
    endtask

    initial begin
        bit sampled;
        int r;
        do_reset;

        // Single pair, adder answers 3 cycles after sample.
        ready_mode = 0;
        push(4'd3, 4'd4, M_NORM, 3);
        drain;

        // Fill the FIFO while the first pair is in flight.
        push(4'd1, 4'd1, M_NORM, 12);
        wait_sample;
        push(4'd15, 4'd15, M_NORM, 2);
        push(4'd0, 4'd0, M_NORM, 1);
        push(4'd9, 4'd8, M_NORM, 5);
        push(4'd7, 4'd12, M_NORM, 4);
        chk("in_ready_when_full", in_ready_o, 1'b0);
        chk("busy_when_full", busy_o, 1'b1);
        push(4'd10, 4'd5, M_NORM, 2);
        drain;

        // Timeout, then a normal pair.
        push(4'd6, 4'd9, M_NEVER, 0);
        push(4'd2, 4'd3, M_NORM, 2);
        drain;

        // Adder returns a wrong sum.
        push(4'd2, 4'd2, M_CORR, 3);
        drain;

        // Stall the result stream with a second pair queued.
        ready_mode = 2;
        push(4'd4, 4'd5, M_NORM, 2);
        push(4'd11, 4'd3, M_NORM, 2);
        r = 0;
        while (!res_valid_o && r < 50) begin
            tick;
            r++;
        end
        chk("stall_res_valid", res_valid_o, 1'b1);
        sampled = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (sample_o) sampled = 1'b1;
        end
        chk("stall_no_second_sample", sampled, 1'b0);
        chk("stall_in_ready", in_ready_o, 1'b1);
        ready_mode = 0;
        drain;

        // Reset in the middle of a transaction abandons it.
        push(4'd6, 4'd7, M_NEVER, 0);
        wait_sample;
        tick;
        tick;
        tick;
        do_reset;
        quiet_window("no_result_after_reset", 25);

        // Spurious done pulse while idle.
        spur = 1'b1;
        quiet_window("spurious_done_idle", 12);
        chk("spurious_done_busy", busy_o, 1'b0);

        // Randomized traffic with random result backpressure.
        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(9);
            push(4'($urandom), 4'($urandom),
                 (r < 2) ? M_CORR : ((r < 3) ? M_NEVER : M_NORM),
                 $urandom_range(12, 1));
            for (int k = $urandom_range(3); k > 0; k--) tick;
        end
        drain;
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule : tb_add_req_sequencer
`default_nettype wire
